// File: rtl/term_pkg.sv
// Shared constants and grant helpers for the terminal input router.
// The command handler can import the same arbitration-mode constants.
package term_pkg;

    localparam int ARB_FIXED    = 0;
    localparam int ARB_RR       = 1;

    // Widest router the helpers support; narrower routers zero-extend.
    localparam int MAX_SRC      = 8;
    localparam int MAX_SRC_BITS = 3;

    typedef struct packed {
        logic                    valid;
        logic [MAX_SRC_BITS-1:0] idx;
    } grant_t;

    // Lowest set request wins.
    function automatic grant_t fixed_grant(input logic [MAX_SRC-1:0] req);
        grant_t g;
        g = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                g.valid = 1'b1;
                g.idx   = MAX_SRC_BITS'(i);
            end
        end
        return g;
    endfunction

    // First set request found searching upward from ptr+1, wrapping at num_src.
    function automatic grant_t rr_next_grant(input logic [MAX_SRC-1:0]      req,
                                             input int                      num_src,
                                             input logic [MAX_SRC_BITS-1:0] ptr);
        grant_t g;
        int     idx;
        g   = '0;
        idx = 0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(ptr) + k) % num_src;
            if (k <= num_src && !g.valid && req[idx]) begin
                g.valid = 1'b1;
                g.idx   = MAX_SRC_BITS'(idx);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/term_sync_fifo.sv
// Small synchronous FIFO used once per router source.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module term_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_en   = push && !full && !flush;
    assign rd_en   = pop && !empty && !flush;

    // Next pointer values: advance on accepted push/pop, clear on flush.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/term_input_router.sv
// N-source byte router: per-source FIFOs, an arbiter draining them into one
// tagged output register, and a forward register copying masked sources
// toward UART TX.
module term_input_router
    import term_pkg::*;
#(
    parameter int                 NUM_SRC    = 2,
    parameter int                 DATA_W     = 8,
    parameter int                 FIFO_DEPTH = 4,
    parameter int                 ARB_MODE   = ARB_FIXED,
    parameter logic [NUM_SRC-1:0] FWD_MASK   = 'b01,
    parameter int                 SRC_BITS   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_BITS-1:0]       out_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      fwd_valid,
    input  logic                      fwd_ready,
    output logic [NUM_SRC-1:0]        fifo_nempty
);

    // Pointer value that makes source 0 the first round-robin winner.
    localparam logic [SRC_BITS-1:0] RR_INIT = SRC_BITS'(NUM_SRC - 1);

    logic [DATA_W-1:0]   fifo_rd_data [NUM_SRC];
    logic [NUM_SRC-1:0]  fifo_full;
    logic [NUM_SRC-1:0]  fifo_empty;
    logic [NUM_SRC-1:0]  fifo_push;
    logic [NUM_SRC-1:0]  fifo_pop;

    logic                fwd_slot_free;
    logic                fwd_taken;
    logic [DATA_W-1:0]   fwd_load_data;

    logic [MAX_SRC-1:0]  req;
    grant_t              grant;
    logic [SRC_BITS-1:0] grant_idx;
    logic                out_load;

    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [SRC_BITS-1:0] out_src_q,   out_src_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   fwd_data_q,  fwd_data_d;
    logic                fwd_valid_q, fwd_valid_d;
    logic [SRC_BITS-1:0] rr_ptr_q,    rr_ptr_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        term_sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .push    (fifo_push[i]),
            .wr_data (src_data[i*DATA_W +: DATA_W]),
            .pop     (fifo_pop[i]),
            .rd_data (fifo_rd_data[i]),
            .full    (fifo_full[i]),
            .empty   (fifo_empty[i])
        );
    end

    assign fwd_slot_free = !fwd_valid_q || fwd_ready;
    assign fifo_nempty   = ~fifo_empty;
    assign out_data      = out_data_q;
    assign out_src       = out_src_q;
    assign out_valid     = out_valid_q;
    assign fwd_data      = fwd_data_q;
    assign fwd_valid     = fwd_valid_q;

    // Source acceptance: only the lowest-index masked transfer may claim the
    // forward slot in a cycle, so higher masked sources are held off.
    always_comb begin
        src_ready     = '0;
        fifo_push     = '0;
        fwd_taken     = 1'b0;
        fwd_load_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = rst_n && !flush && !fifo_full[i] &&
                           (!FWD_MASK[i] || (fwd_slot_free && !fwd_taken));
            fifo_push[i] = src_ready[i] && src_valid[i];
            if (FWD_MASK[i] && fifo_push[i]) begin
                fwd_taken     = 1'b1;
                fwd_load_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Forward register: load a masked beat, otherwise retire it when accepted.
    always_comb begin
        fwd_valid_d = fwd_valid_q;
        fwd_data_d  = fwd_data_q;
        if (flush) begin
            fwd_valid_d = 1'b0;
        end else if (fwd_taken) begin
            fwd_valid_d = 1'b1;
            fwd_data_d  = fwd_load_data;
        end else if (fwd_ready) begin
            fwd_valid_d = 1'b0;
        end
    end

    // Arbitration and output register: pick a non-empty FIFO and pop it into
    // the output register whenever that register is free or being drained.
    always_comb begin
        req                  = '0;
        req[NUM_SRC-1:0]     = ~fifo_empty;
        if (ARB_MODE == ARB_RR) begin
            grant = rr_next_grant(req, NUM_SRC, MAX_SRC_BITS'(rr_ptr_q));
        end else begin
            grant = fixed_grant(req);
        end
        grant_idx = SRC_BITS'(grant.idx);
        out_load  = (!out_valid_q || out_ready) && grant.valid && !flush;

        fifo_pop    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
            rr_ptr_d    = RR_INIT;
        end else if (out_load) begin
            fifo_pop[grant_idx] = 1'b1;
            out_valid_d         = 1'b1;
            out_data_d          = fifo_rd_data[grant_idx];
            out_src_d           = grant_idx;
            rr_ptr_d            = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output, forward and round-robin state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            rr_ptr_q    <= RR_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_term_input_router.sv
// Testbench for term_input_router: a 2-source fixed-priority instance with
// source 0 forwarded, and a 4-source round-robin instance with no forwarding.
module tb_term_input_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;

    // Instance A: 2 sources, fixed priority, source 0 forwarded
    logic [15:0] a_src_data;
    logic [1:0]  a_src_valid, a_src_ready, a_fifo_nempty;
    logic [7:0]  a_out_data, a_fwd_data;
    logic [0:0]  a_out_src;
    logic        a_out_valid, a_out_ready, a_fwd_valid, a_fwd_ready;

    // Instance B: 4 sources, round robin, nothing forwarded
    logic [31:0] b_src_data;
    logic [3:0]  b_src_valid, b_src_ready, b_fifo_nempty;
    logic [7:0]  b_out_data, b_fwd_data;
    logic [1:0]  b_out_src;
    logic        b_out_valid, b_out_ready, b_fwd_valid, b_fwd_ready;

    term_input_router #(
        .NUM_SRC(2), .DATA_W(8), .FIFO_DEPTH(4), .ARB_MODE(0), .FWD_MASK(2'b01)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_data(a_src_data), .src_valid(a_src_valid), .src_ready(a_src_ready),
        .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .fwd_data(a_fwd_data), .fwd_valid(a_fwd_valid), .fwd_ready(a_fwd_ready),
        .fifo_nempty(a_fifo_nempty)
    );

    term_input_router #(
        .NUM_SRC(4), .DATA_W(8), .FIFO_DEPTH(4), .ARB_MODE(1), .FWD_MASK(4'b0000)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_data(b_src_data), .src_valid(b_src_valid), .src_ready(b_src_ready),
        .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .fwd_data(b_fwd_data), .fwd_valid(b_fwd_valid), .fwd_ready(b_fwd_ready),
        .fifo_nempty(b_fifo_nempty)
    );

    typedef struct packed { logic [2:0] src; logic [7:0] data; } beat_t;
    typedef struct packed { int cyc; logic [2:0] src; logic [7:0] data; } obs_t;

    beat_t      sb_a[$];
    beat_t      sb_b[$];
    logic [7:0] fwd_q[$];
    obs_t       log_a[$];
    obs_t       log_b[$];
    logic [7:0] fwd_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mon_a_idx;
    int mon_b_idx;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for instance A: each out beat must be the oldest pending beat of its source.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (a_out_valid && a_out_ready) begin
                mon_a_idx = -1;
                for (int k = 0; k < sb_a.size(); k++)
                    if (mon_a_idx < 0 && sb_a[k].src == {2'b00, a_out_src}) mon_a_idx = k;
                n_checks++;
                if (mon_a_idx < 0) begin
                    n_fail++;
                    $display("FAIL sb_a_unexpected: got src=%0d data=%02h, required no beat (none pending)", a_out_src, a_out_data);
                end else begin
                    if (sb_a[mon_a_idx].data !== a_out_data) begin
                        n_fail++;
                        $display("FAIL sb_a_data: src=%0d got %02h, required %02h", a_out_src, a_out_data, sb_a[mon_a_idx].data);
                    end
                    sb_a.delete(mon_a_idx);
                end
                log_a.push_back('{cyc: cyc, src: {2'b00, a_out_src}, data: a_out_data});
            end
            if (a_fwd_valid && a_fwd_ready) begin
                n_checks++;
                if (fwd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_fwd_unexpected: got %02h, required no beat (none pending)", a_fwd_data);
                end else begin
                    if (fwd_q[0] !== a_fwd_data) begin
                        n_fail++;
                        $display("FAIL sb_fwd_data: got %02h, required %02h", a_fwd_data, fwd_q[0]);
                    end
                    void'(fwd_q.pop_front());
                end
                fwd_log.push_back(a_fwd_data);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (rst_n && !flush && b_out_valid && b_out_ready) begin
            mon_b_idx = -1;
            for (int k = 0; k < sb_b.size(); k++)
                if (mon_b_idx < 0 && sb_b[k].src == {1'b0, b_out_src}) mon_b_idx = k;
            n_checks++;
            if (mon_b_idx < 0) begin
                n_fail++;
                $display("FAIL sb_b_unexpected: got src=%0d data=%02h, required no beat (none pending)", b_out_src, b_out_data);
            end else begin
                if (sb_b[mon_b_idx].data !== b_out_data) begin
                    n_fail++;
                    $display("FAIL sb_b_data: src=%0d got %02h, required %02h", b_out_src, b_out_data, sb_b[mon_b_idx].data);
                end
                sb_b.delete(mon_b_idx);
            end
            log_b.push_back('{cyc: cyc, src: {1'b0, b_out_src}, data: b_out_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat on instance A source s and hold it until accepted.
    task automatic push_a(input int s, input logic [7:0] d);
        bit done;
        done = 1'b0;
        a_src_data[s*8 +: 8] = d;
        a_src_valid[s]       = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (a_src_ready[s]) begin
                sb_a.push_back('{src: 3'(s), data: d});
                if (s == 0) fwd_q.push_back(d);
                done = 1'b1;
            end
            tick();
        end
        a_src_valid[s] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL push_a_timeout: src=%0d data=%02h got no src_ready, required accept within 50 cycles", s, d);
        end
    endtask

    task automatic push_b(input int s, input logic [7:0] d);
        bit done;
        done = 1'b0;
        b_src_data[s*8 +: 8] = d;
        b_src_valid[s]       = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (b_src_ready[s]) begin
                sb_b.push_back('{src: 3'(s), data: d});
                done = 1'b1;
            end
            tick();
        end
        b_src_valid[s] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL push_b_timeout: src=%0d data=%02h got no src_ready, required accept within 50 cycles", s, d);
        end
    endtask

    task automatic wait_drain_a(input int budget);
        for (int t = 0; t < budget && (sb_a.size() != 0 || fwd_q.size() != 0); t++) tick();
        tick();
        n_checks++;
        if (sb_a.size() != 0 || fwd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_a_timeout: got %0d out / %0d fwd beats pending, required 0", sb_a.size(), fwd_q.size());
        end
    endtask

    task automatic wait_drain_b(input int budget);
        for (int t = 0; t < budget && sb_b.size() != 0; t++) tick();
        tick();
        n_checks++;
        if (sb_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain_b_timeout: got %0d beats pending, required 0", sb_b.size());
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        flush       = 1'b0;
        a_src_data  = 16'h2010;
        a_src_valid = 2'b11;
        a_out_ready = 1'b1;
        a_fwd_ready = 1'b1;
        b_src_data  = 32'h0;
        b_src_valid = 4'hF;
        b_out_ready = 1'b1;
        b_fwd_ready = 1'b1;
        tick();
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (a_src_ready !== 2'b00 || b_src_ready !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_ready: got a=%b b=%b, required 0", a_src_ready, b_src_ready);
            end
            n_checks++;
            if (a_out_valid !== 1'b0 || a_fwd_valid !== 1'b0 || b_out_valid !== 1'b0 || b_fwd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid: got out=%b fwd=%b b_out=%b b_fwd=%b, required 0", a_out_valid, a_fwd_valid, b_out_valid, b_fwd_valid);
            end
            n_checks++;
            if (a_out_data !== 8'h00 || a_out_src !== 1'b0 || a_fwd_data !== 8'h00 || a_fifo_nempty !== 2'b00 || b_fifo_nempty !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_regs: got out_data=%02h out_src=%0d fwd_data=%02h nempty=%b/%b, required all 0",
                         a_out_data, a_out_src, a_fwd_data, a_fifo_nempty, b_fifo_nempty);
            end
            tick();
        end
        b_src_valid = 4'h0;
        rst_n       = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_src_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL release_ready: got %b, required 11", a_src_ready);
        end
        if (a_src_ready[0]) begin
            sb_a.push_back('{src: 3'd0, data: 8'h10});
            fwd_q.push_back(8'h10);
        end
        if (a_src_ready[1]) sb_a.push_back('{src: 3'd1, data: 8'h20});
        tick();
        a_src_valid = 2'b00;
        wait_drain_a(20);
        n_checks++;
        if (log_a.size() < 1 || log_a[0].src !== 3'd0 || log_a[0].data !== 8'h10) begin
            n_fail++;
            $display("FAIL release_first_beat: got %0d beats (first src=%0d data=%02h), required src=0 data=10",
                     log_a.size(), (log_a.size() > 0) ? log_a[0].src : 3'd7, (log_a.size() > 0) ? log_a[0].data : 8'hxx);
        end
    endtask

    task automatic test_fixed_priority();
        logic [7:0] exp_d [4];
        logic [2:0] exp_s [4];
        exp_d = '{8'h31, 8'h41, 8'h32, 8'h33};
        exp_s = '{3'd1, 3'd0, 3'd1, 3'd1};
        log_a.delete();
        a_out_ready = 1'b0;
        push_a(1, 8'h31);
        push_a(1, 8'h32);
        push_a(1, 8'h33);
        push_a(0, 8'h41);
        tick();
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'h31 || a_out_src !== 1'b1) begin
            n_fail++;
            $display("FAIL fp_held: got valid=%b data=%02h src=%0d, required 1/31/1", a_out_valid, a_out_data, a_out_src);
        end
        n_checks++;
        if (a_fifo_nempty !== 2'b11) begin
            n_fail++;
            $display("FAIL fp_nempty: got %b, required 11", a_fifo_nempty);
        end
        tick();
        a_out_ready = 1'b1;
        wait_drain_a(30);
        n_checks++;
        if (log_a.size() != 4) begin
            n_fail++;
            $display("FAIL fp_count: got %0d beats, required 4", log_a.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (log_a[k].src !== exp_s[k] || log_a[k].data !== exp_d[k]) begin
                    n_fail++;
                    $display("FAIL fp_order[%0d]: got src=%0d data=%02h, required src=%0d data=%02h",
                             k, log_a[k].src, log_a[k].data, exp_s[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        log_a.delete();
        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_a(1, 8'(8'h51 + k));
        a_src_data[15:8] = 8'h56;
        a_src_valid[1]   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_src_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: got src_ready[1]=%b, required 0", a_src_ready[1]);
        end
        n_checks++;
        if (a_fifo_nempty !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_nempty: got %b, required 10", a_fifo_nempty);
        end
        tick();
        a_out_ready = 1'b1;
        push_a(1, 8'h56);
        for (int k = 0; k < 6; k++) push_a(1, 8'(8'h61 + k));
        wait_drain_a(40);
        n_checks++;
        if (log_a.size() != 12) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats, required 12", log_a.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                logic [7:0] exp;
                exp = (k < 6) ? 8'(8'h51 + k) : 8'(8'h61 + k - 6);
                n_checks++;
                if (log_a[k].src !== 3'd1 || log_a[k].data !== exp) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got src=%0d data=%02h, required src=1 data=%02h",
                             k, log_a[k].src, log_a[k].data, exp);
                end
            end
        end
    endtask

    task automatic test_fwd_stall();
        log_a.delete();
        fwd_log.delete();
        a_out_ready = 1'b1;
        a_fwd_ready = 1'b1;
        push_a(0, 8'h1B);
        a_fwd_ready     = 1'b0;
        a_src_data[7:0] = 8'h41;
        a_src_valid[0]  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (a_src_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL fwd_stall_ready: got src_ready[0]=%b, required 0", a_src_ready[0]);
            end
            n_checks++;
            if (a_fwd_valid !== 1'b1 || a_fwd_data !== 8'h1B) begin
                n_fail++;
                $display("FAIL fwd_stall_hold: got valid=%b data=%02h, required 1/1b", a_fwd_valid, a_fwd_data);
            end
            tick();
        end
        a_fwd_ready = 1'b1;
        push_a(0, 8'h41);
        wait_drain_a(20);
        n_checks++;
        if (log_a.size() != 2 || log_a[0].data !== 8'h1B || log_a[1].data !== 8'h41) begin
            n_fail++;
            $display("FAIL fwd_out_seq: got %0d beats, required exactly 1b,41", log_a.size());
        end
        n_checks++;
        if (fwd_log.size() != 2 || fwd_log[0] !== 8'h1B || fwd_log[1] !== 8'h41) begin
            n_fail++;
            $display("FAIL fwd_fwd_seq: got %0d beats, required exactly 1b,41", fwd_log.size());
        end
    endtask

    task automatic test_flush();
        log_a.delete();
        a_out_ready = 1'b0;
        a_fwd_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_a(1, 8'(8'h71 + k));
        tick();
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b1 || a_fifo_nempty !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_pre: got out_valid=%b nempty=%b, required 1/10", a_out_valid, a_fifo_nempty);
        end
        tick();
        flush           = 1'b1;
        a_src_data[7:0] = 8'h77;
        a_src_valid[0]  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_src_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_ready: got %b, required 00", a_src_ready);
        end
        tick();
        flush       = 1'b0;
        a_src_valid = 2'b00;
        sb_a.delete();
        fwd_q.delete();
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_fifo_nempty !== 2'b00 || a_fwd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_post: got out_valid=%b nempty=%b fwd_valid=%b, required 0/00/0", a_out_valid, a_fifo_nempty, a_fwd_valid);
        end
        tick();
        a_out_ready = 1'b1;
        push_a(1, 8'h88);
        wait_drain_a(20);
        n_checks++;
        if (log_a.size() != 1 || log_a[0].src !== 3'd1 || log_a[0].data !== 8'h88) begin
            n_fail++;
            $display("FAIL flush_after: got %0d beats, required exactly src=1 data=88", log_a.size());
        end
    endtask

    task automatic test_round_robin();
        log_b.delete();
        b_out_ready = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < ((s == 0) ? 5 : 4); k++)
                push_b(s, 8'(s * 16 + k));
        tick();
        @(negedge clk);
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_src !== 2'd0 || b_out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rr_first: got valid=%b src=%0d data=%02h, required 1/0/00", b_out_valid, b_out_src, b_out_data);
        end
        n_checks++;
        if (b_fifo_nempty !== 4'hF || b_src_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL rr_full: got nempty=%b ready=%b, required 1111/0000", b_fifo_nempty, b_src_ready);
        end
        tick();
        b_out_ready = 1'b1;
        wait_drain_b(40);
        n_checks++;
        if (log_b.size() != 17) begin
            n_fail++;
            $display("FAIL rr_count: got %0d beats, required 17", log_b.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                n_checks++;
                if (log_b[k].src !== 3'(k % 4) || log_b[k].data !== 8'((k % 4) * 16 + k / 4) ||
                    log_b[k].cyc != log_b[0].cyc + k) begin
                    n_fail++;
                    $display("FAIL rr_seq[%0d]: got src=%0d data=%02h cycle+%0d, required src=%0d data=%02h cycle+%0d",
                             k, log_b[k].src, log_b[k].data, log_b[k].cyc - log_b[0].cyc, k % 4, (k % 4) * 16 + k / 4, k);
                end
            end
        end
        n_checks++;
        if (b_fwd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_no_fwd: got fwd_valid=%b, required 0", b_fwd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_backpressure();
        test_fwd_stall();
        test_flush();
        test_round_robin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/term_input_router.md
# term_input_router

Parametrised N-source byte router that replaces the fixed two-input keyboard/UART multiplexer and the single-register keyboard-to-TX path in the terminal top. Each source (PS/2 keyboard, UART RX, future host/loopback ports) feeds its own small FIFO. A fixed-priority or round-robin arbiter drains the FIFOs into one registered stream, tagged with its source index, toward the command handler. Sources selected by a mask are also copied onto a forward stream toward UART TX (local keystrokes to host).

## Interface
- NUM_SRC, 2: number of input sources, 2..8.
- DATA_W, 8: beat width.
- FIFO_DEPTH, 4: per-source FIFO depth, power of two, 2..16.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round robin.
- FWD_MASK, 'b01: bit i set means source i is also copied to the forward stream.
- SRC_BITS, $clog2(NUM_SRC) (min 1): width of the source tag.

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset; synchronous and active-low.
- flush  in  1  synchronous clear of all buffered data.
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- src_valid  in  NUM_SRC  per-source valid.
- src_ready  out  NUM_SRC  per-source ready.
- out_data  out  DATA_W  routed beat (registered).
- out_src  out  SRC_BITS  index of the source that supplied out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the output beat.
- fwd_data  out  DATA_W  forward beat (registered).
- fwd_valid  out  1  forward beat valid.
- fwd_ready  in  1  forward sink accepts (UART tx_ready).
- fifo_nempty  out  NUM_SRC  per-FIFO non-empty flags, for status LEDs.

## Operation
- A beat transfers on any interface when valid && ready at a rising edge. Once valid is raised, it holds with stable data until accepted; this applies to out_* and fwd_*.
- src_ready[i] = rst_n && !flush && !full[i] && (!FWD_MASK[i] || fwd_slot_free). fwd_slot_free = !fwd_valid || fwd_ready.
  - src_ready is combinational from registered state plus fwd_ready, flush and rst_n. A pop in the same cycle does not raise src_ready on a full FIFO.
- Forward arbitration: if several masked sources transfer in the same cycle, only the lowest index is loaded into fwd_data. The other masked sources' src_ready is forced low that cycle, so no beat is lost.
- The output register loads when out_valid==0 or out_ready==1, and at least one FIFO is non-empty. The granted FIFO pops in the same edge.
- Fixed priority: grant the lowest non-empty index.
- Round robin: search from rr_ptr+1 upward with wrap-around, grant the first non-empty FIFO, then set rr_ptr to the grant. rr_ptr holds when there is no grant.
- FIFO: write and read pointers are SRC-local and one bit wider than $clog2(FIFO_DEPTH). Full when the MSBs differ and the rest are equal; empty when equal. Pointers wrap modulo 2*FIFO_DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy unchanged.
- flush=1 at an edge:
  - all FIFO pointers return to zero;
  - out_valid and fwd_valid go to 0;
  - rr_ptr goes to NUM_SRC-1;
  - all handshakes that cycle are ignored.
- Reset, including mid-operation, has the same effect as flush and additionally sets out_data, fwd_data and out_src to 0.

## Timing
- Reset values: src_ready=0 while rst_n=0. out_valid=0, out_data=0, out_src=0, fwd_valid=0, fwd_data=0, fifo_nempty=0, rr_ptr=NUM_SRC-1 (source 0 wins first).
- Minimum latency: a beat accepted at edge E appears on out_* after edge E+1. There is no empty-FIFO bypass.
- Forward latency: a beat accepted at edge E appears on fwd_* after edge E, i.e. the next cycle.
- Sustained throughput is 1 beat/cycle on out_* when out_ready stays high and any FIFO is non-empty.
- Throughput per masked source is bounded by fwd_ready. UART TX backpressure stalls that source at its src_ready; it never drops beats.

## Structure
- Package term_pkg holds ARB_FIXED=0 and ARB_RR=1, plus a function that gives the round-robin next-grant for a request vector and pointer. The command handler may later import the same constants.
- Sub-module term_sync_fifo(DATA_W, DEPTH) is instantiated NUM_SRC times in a generate loop. The arbiter, output register and forward register stay in the parent.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with src_valid=all ones -> src_ready=0, out_valid=0, fwd_valid=0. After release, the first out beat comes from source 0.
- Fixed priority: NUM_SRC=2, ARB_MODE=0. Load 3 beats into source 1, then 0x41 into source 0 while out_ready=0. Raise out_ready -> the beat already in the output register drains, then 0x41/out_src=0, then the rest of source 1.
- Round robin: NUM_SRC=4, ARB_MODE=1, all FIFOs full with tags 0xi0.., out_ready=1 -> out_src sequence 0,1,2,3,0,1,... at one beat per cycle.
- Backpressure/full: FIFO_DEPTH=4 with out_ready=0. Source 1 pushes 5 beats (one is held in the output register) -> the 6th push sees src_ready[1]=0. Then source 1 (0x61..0x66) with out_ready=1 -> no loss or duplication, in order.
- Forward stall: FWD_MASK=01 with fwd_ready=0 after the first beat. Keyboard sends 0x1B,0x41 -> src_ready[0] stays low until fwd_ready=1. out_* and fwd_* each carry 0x1B then 0x41 exactly once.
- Flush mid-stream: with 3 beats buffered and out_valid=1, pulse flush -> out_valid=0 and fifo_nempty=0 next cycle, and beats presented during the flush cycle are discarded.
